dct_block_gather: RTL and testbench
===================================

DCT_BLOCK_GATHER -- requirements
Module: dct_block_gather

Interface
REQ-001 Parameter DATA_W, default 32; width of one sample word (two's-complement fixed point, passed through unmodified).
REQ-002 Parameter LANES, default 8; words per input beat, legal values 1, 2, 4, 8.
REQ-003 Parameter BLK_WORDS, default 64; words per block, a multiple of LANES; BEATS = BLK_WORDS/LANES.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; asynchronous assert, active-high.
REQ-006 s_valid  in  1  input beat valid.
REQ-007 s_ready  out  1  gather can accept a beat.
REQ-008 s_data  in  LANES*DATA_W  lane k in bits [k*DATA_W +: DATA_W].
REQ-009 s_last  in  1  producer marks final beat of a block.
REQ-010 m_valid  out  1  complete block available.
REQ-011 m_ready  in  1  downstream (block-parallel DCT) accepts block.
REQ-012 m_data  out  BLK_WORDS*DATA_W  word i in bits [i*DATA_W +: DATA_W], row-major.
REQ-013 m_err  out  1  framing error flag for the presented block, qualified by m_valid.
REQ-014 occ  out  2  number of full buffers (0..2).

Function
REQ-015 Block SHALL hold two block buffers (ping-pong), each BLK_WORDS words, plus a full flag per buffer.
REQ-016 Write side: beat counter beat_cnt (0..BEATS-1) and write select wr_sel; s_ready SHALL equal !full[wr_sel].
REQ-017 On s_valid && s_ready, lane k of beat b SHALL be written to word b*LANES+k of buffer wr_sel; beat_cnt increments.
REQ-018 On acceptance with beat_cnt==BEATS-1: full[wr_sel] set, wr_sel toggles, beat_cnt wraps to 0.
REQ-019 Read side: read select rd_sel; m_valid SHALL equal full[rd_sel]; m_data SHALL present buffer rd_sel combinationally.
REQ-020 On m_valid && m_ready: full[rd_sel] cleared, rd_sel toggles.
REQ-021 Latency: m_valid SHALL assert the cycle after the final beat is accepted, when the other buffer is not ahead of it.
REQ-022 m_data and m_err SHALL remain stable while m_valid && !m_ready.
REQ-023 Simultaneous final-beat write to one buffer and drain of the other in the same cycle SHALL both take effect; no beat lost.
REQ-024 Both buffers full: s_ready low until a drain; s_ready SHALL rise the cycle after the drain handshake.
REQ-025 Sustained throughput SHALL be one beat per cycle when m_ready is asserted at least once every BEATS cycles.
REQ-026 occ SHALL equal full[0]+full[1], registered view of the flags.
REQ-027 Blocks SHALL be emitted in arrival order; no reordering of words within a block.

Reset
REQ-028 While rst high: beat_cnt=0, wr_sel=0, rd_sel=0, full=00, per-buffer error bits=0; hence m_valid=0, s_ready=1, occ=0, m_err=0.
REQ-029 Buffer data registers SHALL NOT be reset; m_data content is don't-care while m_valid=0.
REQ-030 Reset mid-block SHALL discard partial and complete-but-undrained blocks; first beat after release is beat 0 of a new block.

Configuration
REQ-031 Macro DCT_GATHER_LAST_CHK_EN defined: each buffer carries an error bit, set if any accepted beat has s_last mismatching (beat_cnt==BEATS-1); m_err presents the error bit of buffer rd_sel; counting is not resynchronised by s_last.
REQ-032 Macro undefined: s_last ignored, m_err tied 0, no error-bit storage.

Verification (LANES=8, BLK_WORDS=64, BEATS=8)
REQ-033 Reset then 8 beats, beat b lane k = b*8+k, m_ready=1 -> m_valid one cycle after 8th beat, word i of m_data = i, occ returns 0.
REQ-034 m_ready=0, stream 16 beats back-to-back -> s_ready stays 1 for 16 beats then falls, occ=2; 17th beat stalls until m_ready pulse, s_ready=1 the following cycle.
REQ-035 Continuous s_valid, m_ready pulsed every 8th cycle for 100 blocks -> 800 beats accepted in 800 cycles, all blocks match in order.
REQ-036 Final beat of block B accepted in same cycle block A drained (occ=1 beforehand) -> occ stays 1, m_valid stays high, next m_data = block B.
REQ-037 rst pulsed after 5 beats of a block with one full buffer pending -> m_valid=0, occ=0, s_ready=1; next 8 beats form a correct block.
REQ-038 DCT_GATHER_LAST_CHK_EN defined, s_last on beat 3 and not beat 7 -> m_err=1 with that block; next correctly framed block -> m_err=0; macro undefined -> m_err=0 for both.

Source files
------------

// File: rtl/dct_block_gather.sv
// dct_block_gather: ping-pong gather of LANES-wide beats into full
// BLK_WORDS-word blocks for a block-parallel DCT.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_valid/s_ready input beat handshake
//   s_data          LANES words, lane k at [k*DATA_W +: DATA_W]
//   s_last          producer end-of-block marker
//   m_valid/m_ready block handshake toward the DCT
//   m_data          BLK_WORDS words, word i at [i*DATA_W +: DATA_W]
//   m_err           framing error of the presented block
//   occ             number of full buffers (0..2)
//
// Optional feature: define DCT_GATHER_LAST_CHK_EN to track a per-buffer
// framing error from s_last; otherwise s_last is ignored and m_err is 0.

module dct_block_gather #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 8,
    parameter int BLK_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_W-1:0]     s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [BLK_WORDS*DATA_W-1:0] m_data,
    output logic                        m_err,
    output logic [1:0]                  occ
);

    localparam int BEATS = BLK_WORDS / LANES;
    localparam int BW    = LANES * DATA_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          wr_sel, wr_sel_nxt;
    logic          rd_sel, rd_sel_nxt;
    logic [1:0]    full, full_nxt;
    logic          s_acc, m_acc, at_last;

    // Data storage is deliberately not reset.
    logic [BW-1:0] mem [2][BEATS];

    assign s_ready = !full[wr_sel];
    assign m_valid = full[rd_sel];
    assign s_acc   = s_valid && s_ready;
    assign m_acc   = m_valid && m_ready;
    assign at_last = (beat_cnt == LAST_BEAT);
    assign occ     = {1'b0, full[0]} + {1'b0, full[1]};

    // Write and drain always target different buffers (one is empty,
    // the other full), so both updates to full_nxt can land together.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        wr_sel_nxt   = wr_sel;
        rd_sel_nxt   = rd_sel;
        full_nxt     = full;
        if (s_acc) begin
            if (at_last) begin
                beat_cnt_nxt     = '0;
                wr_sel_nxt       = !wr_sel;
                full_nxt[wr_sel] = 1'b1;
            end else begin
                beat_cnt_nxt = beat_cnt + 1'b1;
            end
        end
        if (m_acc) begin
            full_nxt[rd_sel] = 1'b0;
            rd_sel_nxt       = !rd_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            full     <= 2'b00;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            wr_sel   <= wr_sel_nxt;
            rd_sel   <= rd_sel_nxt;
            full     <= full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (s_acc) begin
            mem[wr_sel][beat_cnt] <= s_data;
        end
    end

    always_comb begin
        m_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            m_data[b*BW +: BW] = mem[rd_sel][b];
        end
    end

`ifdef DCT_GATHER_LAST_CHK_EN
    logic [1:0] err, err_nxt;
    logic       frame_bad;

    // Counting is never resynchronised by s_last; a disagreement with
    // the beat counter just marks the block being filled.
    assign frame_bad = (s_last != at_last);

    always_comb begin
        err_nxt = err;
        if (s_acc) begin
            err_nxt[wr_sel] = ((beat_cnt == '0) ? 1'b0 : err[wr_sel])
                              | frame_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 2'b00;
        end else begin
            err <= err_nxt;
        end
    end

    assign m_err = err[rd_sel];
`else
    logic unused_last;

    assign unused_last = s_last;
    assign m_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dct_block_gather.sv
// tb_dct_block_gather: directed self-checking bench for dct_block_gather
// with LANES=8, BLK_WORDS=64 (8 beats per block).

module tb_dct_block_gather;

    localparam int DW    = 32;
    localparam int LN    = 8;
    localparam int NW    = 64;
    localparam int BEATS = 8;

`ifdef DCT_GATHER_LAST_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [LN*DW-1:0] s_data;
    logic            s_last;
    logic            m_valid;
    logic            m_ready;
    logic [NW*DW-1:0] m_data;
    logic            m_err;
    logic [1:0]      occ;

    int checks = 0;
    int errors = 0;

    dct_block_gather #(
        .DATA_W    (DW),
        .LANES     (LN),
        .BLK_WORDS (NW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_err   (m_err),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wval(input int blk, input int i);
        return 32'(blk * 256 + i);
    endfunction

    function automatic logic [LN*DW-1:0] beat(input int blk, input int b);
        logic [LN*DW-1:0] v;
        for (int k = 0; k < LN; k++) v[k*DW +: DW] = wval(blk, b*LN + k);
        return v;
    endfunction

    // One comparison per block: the first wrong word, or word 0.
    task automatic check_blk(input string tag, input int blk);
        int j = 0;
        for (int i = NW - 1; i >= 0; i--)
            if (m_data[i*DW +: DW] !== wval(blk, i)) j = i;
        check(tag, 64'(m_data[j*DW +: DW]), 64'(wval(blk, j)));
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input int blk, input int b, input bit lst);
        int n = 0;
        s_valid = 1'b1;
        s_data  = beat(blk, b);
        s_last  = lst;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'(n), 64'(0));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_blk(input int blk);
        for (int b = 0; b < BEATS; b++) send(blk, b, b == BEATS - 1);
    endtask

    task automatic drain(input string tag, input int blk);
        int n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'(n), 64'(0));
        check_blk(tag, blk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        int rdy;
        int acc;
        int rd;
        int done_cyc;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mvalid", 64'(m_valid), 64'(0));
        check("rst_sready", 64'(s_ready), 64'(1));
        check("rst_occ", 64'(occ), 64'(0));
        check("rst_merr", 64'(m_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single block with m_ready held high.
        m_ready = 1'b1;
        send_blk(0);
        check("t1_mvalid", 64'(m_valid), 64'(1));
        check_blk("t1_data", 0);
        check("t1_occ1", 64'(occ), 64'(1));
        @(negedge clk);
        m_ready = 1'b0;
        check("t1_mvalid0", 64'(m_valid), 64'(0));
        check("t1_occ0", 64'(occ), 64'(0));

        // Fill both buffers, then stall the 17th beat.
        rdy = 0;
        for (int b = 0; b < 2 * BEATS; b++) begin
            if (s_ready) rdy++;
            send(1 + b / BEATS, b % BEATS, (b % BEATS) == BEATS - 1);
        end
        check("t2_ready16", 64'(rdy), 64'(16));
        check("t2_sready0", 64'(s_ready), 64'(0));
        check("t2_occ2", 64'(occ), 64'(2));
        check("t2_mvalid", 64'(m_valid), 64'(1));
        s_valid = 1'b1;
        s_data  = beat(3, 0);
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_stall", 64'(s_ready), 64'(0));
        check_blk("t2_blkA", 1);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("t2_sready_rise", 64'(s_ready), 64'(1));
        check("t2_occ1", 64'(occ), 64'(1));
        @(negedge clk);
        for (int b = 1; b < BEATS; b++) send(3, b, b == BEATS - 1);
        drain("t2_blkB", 2);
        drain("t2_blkC", 3);
        check("t2_occ0", 64'(occ), 64'(0));

        // Final beat of block B coincides with drain of block A.
        send_blk(4);
        for (int b = 0; b < BEATS - 1; b++) send(5, b, 1'b0);
        s_valid = 1'b1;
        s_data  = beat(5, BEATS - 1);
        s_last  = 1'b1;
        m_ready = 1'b1;
        check_blk("t3_blkA", 4);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        check("t3_occ", 64'(occ), 64'(1));
        check("t3_mvalid", 64'(m_valid), 64'(1));
        drain("t3_blkB", 5);

        // Reset with one full buffer and a partial block.
        send_blk(6);
        for (int b = 0; b < 5; b++) send(7, b, 1'b0);
        rst = 1'b1;
        #2;
        check("t4_mvalid", 64'(m_valid), 64'(0));
        check("t4_occ", 64'(occ), 64'(0));
        check("t4_sready", 64'(s_ready), 64'(1));
        check("t4_merr", 64'(m_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_blk(8);
        check("t4_occ1", 64'(occ), 64'(1));
        drain("t4_blk", 8);
        check("t4_occ0", 64'(occ), 64'(0));

        // Framing check: s_last on beat 3 instead of beat 7.
        for (int b = 0; b < BEATS; b++) send(9, b, b == 3);
        check("t5_merr_bad", 64'(m_err), 64'(CHK));
        drain("t5_blk_bad", 9);
        send_blk(10);
        check("t5_merr_ok", 64'(m_err), 64'(0));
        drain("t5_blk_ok", 10);

        // Sustained streaming with m_ready pulsed every 8th cycle.
        acc      = 0;
        rd       = 0;
        done_cyc = -1;
        for (int c = 0; c < 802; c++) begin
            s_valid = (acc < 800);
            s_data  = beat(100 + acc / BEATS, acc % BEATS);
            s_last  = (acc % BEATS) == BEATS - 1;
            m_ready = (c >= 8) && (c % 8 == 0);
            if (m_valid && m_ready) begin
                check_blk("thru_blk", 100 + rd);
                rd++;
            end
            if (s_valid && s_ready) begin
                acc++;
                if (acc == 800) done_cyc = c + 1;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("thru_beats", 64'(acc), 64'(800));
        check("thru_cycles", 64'(done_cyc), 64'(800));
        check("thru_blocks", 64'(rd), 64'(100));
        check("thru_occ", 64'(occ), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
